// File: rtl/rtc_alarm_pkg.sv
// Shared types and constants for the RTC alarm stage and its helpers.
package rtc_alarm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2
   } alarm_state_t;

   localparam int MASK_SEC  = 0;
   localparam int MASK_MIN  = 1;
   localparam int MASK_HOUR = 2;
   localparam int MASK_DAY  = 3;

   localparam int HOURS_PER_HALF_DAY = 12;

endpackage

// File: rtl/rtc_alarm_if.sv
// Signal bundle between the RTC counter/host side (master) and the alarm stage (slave).
interface rtc_alarm_if;

   logic [5:0] cur_sec_i;
   logic [5:0] cur_min_i;
   logic [5:0] cur_hour_i;
   logic [1:0] cur_mode_i;
   logic [2:0] cur_day_of_week_i;
   logic [4:0] cur_day_of_month_i;
   logic       alarm_en_i;
   logic       alarm_wr_i;
   logic [5:0] alarm_sec_i;
   logic [5:0] alarm_min_i;
   logic [4:0] alarm_hour_i;
   logic [4:0] alarm_day_i;
   logic       alarm_dy_dt_i;
   logic [3:0] alarm_mask_i;
   logic       snooze_i;
   logic       stop_i;
   logic       flag_clr_i;
   logic       alarm_flag_o;
   logic       irq_o;
   logic       ring_o;
   logic       snoozing_o;

   modport master (
      output cur_sec_i, cur_min_i, cur_hour_i, cur_mode_i,
             cur_day_of_week_i, cur_day_of_month_i,
             alarm_en_i, alarm_wr_i, alarm_sec_i, alarm_min_i, alarm_hour_i,
             alarm_day_i, alarm_dy_dt_i, alarm_mask_i,
             snooze_i, stop_i, flag_clr_i,
      input  alarm_flag_o, irq_o, ring_o, snoozing_o
   );

   modport slave (
      input  cur_sec_i, cur_min_i, cur_hour_i, cur_mode_i,
             cur_day_of_week_i, cur_day_of_month_i,
             alarm_en_i, alarm_wr_i, alarm_sec_i, alarm_min_i, alarm_hour_i,
             alarm_day_i, alarm_dy_dt_i, alarm_mask_i,
             snooze_i, stop_i, flag_clr_i,
      output alarm_flag_o, irq_o, ring_o, snoozing_o
   );

endinterface

// File: rtl/rtc_hour_to_24h.sv
// Combinational 12 h / 24 h hour normalisation; output is always 0-23.
module rtc_hour_to_24h
   import rtc_alarm_pkg::*;
(
   input  logic [5:0] hour,
   input  logic       is_12h,
   input  logic       is_pm,
   output logic [5:0] hour24
);

   localparam logic [5:0] HALF_DAY = 6'(HOURS_PER_HALF_DAY);

   always_comb begin
      hour24 = hour;
      if (is_12h) begin
         // 12 is the first hour of each half, so it maps to 0 (AM) or stays 12 (PM)
         if (hour == HALF_DAY) begin
            hour24 = is_pm ? HALF_DAY : 6'd0;
         end else if (is_pm) begin
            hour24 = hour + HALF_DAY;
         end
      end
   end

endmodule

// File: rtl/rtc_alarm.sv
// Alarm compare, sticky flag, irq pulse and ring/snooze FSM on the 1 Hz RTC clock.
module rtc_alarm
   import rtc_alarm_pkg::*;
#(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int MAX_SNOOZE = 3
) (
   input logic        clk_1Hz_i,
   input logic        rstn_i,
   rtc_alarm_if.slave bus
);

   localparam int CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int SC_W    = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

   localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SEC - 1);
   localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SEC - 1);
   localparam logic [SC_W-1:0]  SNOOZE_LIM  = SC_W'(MAX_SNOOZE);

   logic [5:0]       alarm_sec_reg;
   logic [5:0]       alarm_min_reg;
   logic [4:0]       alarm_hour_reg;
   logic [4:0]       alarm_day_reg;
   logic             alarm_dy_dt_reg;
   logic [3:0]       alarm_mask_reg;
   logic [5:0]       prev_sec_reg;
   alarm_state_t     state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [SC_W-1:0]  snooze_cnt_reg, snooze_cnt_next;
   logic             flag_reg, flag_next;
   logic             irq_reg;

   logic [5:0] hour24;
   logic [3:0] field_eq;
   logic [3:0] field_ok;
   logic       match;
   logic       trigger;

   rtc_hour_to_24h u_hour (
      .hour   (bus.cur_hour_i),
      .is_12h (bus.cur_mode_i[0]),
      .is_pm  (bus.cur_mode_i[1]),
      .hour24 (hour24)
   );

   assign field_eq[MASK_SEC]  = (bus.cur_sec_i == alarm_sec_reg);
   assign field_eq[MASK_MIN]  = (bus.cur_min_i == alarm_min_reg);
   assign field_eq[MASK_HOUR] = (hour24 == {1'b0, alarm_hour_reg});
   assign field_eq[MASK_DAY]  = alarm_dy_dt_reg
                              ? (alarm_day_reg == {2'b00, bus.cur_day_of_week_i})
                              : (alarm_day_reg == bus.cur_day_of_month_i);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_field
         assign field_ok[gi] = alarm_mask_reg[gi] | field_eq[gi];
      end
   endgenerate

   assign match = &field_ok;

   // Edge on the seconds field makes a stalled counter unable to re-trigger
   assign trigger = bus.alarm_en_i & match & (bus.cur_sec_i != prev_sec_reg) & ~bus.alarm_wr_i;

   always_comb begin
      flag_next = flag_reg;
      if (trigger) begin
         flag_next = 1'b1;
      end else if (bus.flag_clr_i && !bus.alarm_wr_i) begin
         flag_next = 1'b0;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      snooze_cnt_next = snooze_cnt_reg;
      if (bus.alarm_wr_i || !bus.alarm_en_i || bus.stop_i) begin
         state_next = IDLE;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (trigger) begin
                  state_next      = RINGING;
                  cnt_next        = RING_LOAD;
                  snooze_cnt_next = '0;
               end
            end
            RINGING: begin
               if (bus.snooze_i) begin
                  if (snooze_cnt_reg < SNOOZE_LIM) begin
                     state_next      = SNOOZE;
                     cnt_next        = SNOOZE_LOAD;
                     snooze_cnt_next = snooze_cnt_reg + 1'b1;
                  end else begin
                     state_next = IDLE;
                  end
               end else if (cnt_reg == '0) begin
                  state_next = IDLE;
               end else begin
                  cnt_next = cnt_reg - 1'b1;
               end
            end
            SNOOZE: begin
               if (trigger || cnt_reg == '0) begin
                  state_next = RINGING;
                  cnt_next   = RING_LOAD;
               end else begin
                  cnt_next = cnt_reg - 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_1Hz_i) begin
      if (!rstn_i) begin
         alarm_sec_reg   <= '0;
         alarm_min_reg   <= '0;
         alarm_hour_reg  <= '0;
         alarm_day_reg   <= '0;
         alarm_dy_dt_reg <= 1'b0;
         alarm_mask_reg  <= 4'b1111;
         prev_sec_reg    <= '0;
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         snooze_cnt_reg  <= '0;
         flag_reg        <= 1'b0;
         irq_reg         <= 1'b0;
      end else begin
         if (bus.alarm_wr_i) begin
            alarm_sec_reg   <= bus.alarm_sec_i;
            alarm_min_reg   <= bus.alarm_min_i;
            alarm_hour_reg  <= bus.alarm_hour_i;
            alarm_day_reg   <= bus.alarm_day_i;
            alarm_dy_dt_reg <= bus.alarm_dy_dt_i;
            alarm_mask_reg  <= bus.alarm_mask_i;
         end
         prev_sec_reg   <= bus.cur_sec_i;
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         snooze_cnt_reg <= snooze_cnt_next;
         flag_reg       <= flag_next;
         irq_reg        <= trigger;
      end
   end

   assign bus.alarm_flag_o = flag_reg;
   assign bus.irq_o        = irq_reg;
   assign bus.ring_o       = (state_reg == RINGING);
   assign bus.snoozing_o   = (state_reg == SNOOZE);

endmodule

// File: tb/tb_rtc_alarm.sv
// Directed bench for rtc_alarm: compare, 12 h mapping, masks, flag, ring/snooze timing.
module tb_rtc_alarm;

   logic clk;
   logic rstn;
   int   tests_run;
   int   tests_failed;

   rtc_alarm_if bus ();

   rtc_alarm #(
      .RING_SEC   (60),
      .SNOOZE_SEC (300),
      .MAX_SNOOZE (3)
   ) dut (
      .clk_1Hz_i (clk),
      .rstn_i    (rstn),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input int obs, input int exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s = %0d", tag, obs);
      end
   endtask

   task automatic set_time(input logic [5:0] s, input logic [5:0] m,
                           input logic [5:0] h, input logic [1:0] mode);
      bus.cur_sec_i  = s;
      bus.cur_min_i  = m;
      bus.cur_hour_i = h;
      bus.cur_mode_i = mode;
   endtask

   task automatic program_alarm(input logic [5:0] s, input logic [5:0] m,
                                input logic [4:0] h, input logic [4:0] d,
                                input logic dydt, input logic [3:0] mask);
      bus.alarm_sec_i   = s;
      bus.alarm_min_i   = m;
      bus.alarm_hour_i  = h;
      bus.alarm_day_i   = d;
      bus.alarm_dy_dt_i = dydt;
      bus.alarm_mask_i  = mask;
      bus.alarm_wr_i    = 1'b1;
      step();
      bus.alarm_wr_i    = 1'b0;
   endtask

   // Present hh:00:01 then hh:00:00 so the seconds field changes onto the alarm second
   task automatic try_time(input string tag, input logic [5:0] h,
                           input logic [1:0] mode, input int exp_irq);
      set_time(6'd1, 6'd0, h, mode);
      step();
      set_time(6'd0, 6'd0, h, mode);
      step();
      check_eq(tag, int'(bus.irq_o), exp_irq);
   endtask

   task automatic pulse_snooze();
      bus.snooze_i = 1'b1;
      step();
      bus.snooze_i = 1'b0;
   endtask

   initial begin
      int ring_n;
      int irq_n;
      int snz_n;

      tests_run    = 0;
      tests_failed = 0;
      rstn = 1'b0;
      set_time(6'd0, 6'd0, 6'd0, 2'b00);
      bus.cur_day_of_week_i  = 3'd1;
      bus.cur_day_of_month_i = 5'd1;
      bus.alarm_en_i   = 1'b0;
      bus.alarm_wr_i   = 1'b0;
      bus.alarm_sec_i  = '0;
      bus.alarm_min_i  = '0;
      bus.alarm_hour_i = '0;
      bus.alarm_day_i  = '0;
      bus.alarm_dy_dt_i = 1'b0;
      bus.alarm_mask_i = '0;
      bus.snooze_i   = 1'b0;
      bus.stop_i     = 1'b0;
      bus.flag_clr_i = 1'b0;
      step();
      step();
      check_eq("rst_ring", int'(bus.ring_o), 0);
      check_eq("rst_snoozing", int'(bus.snoozing_o), 0);
      check_eq("rst_flag", int'(bus.alarm_flag_o), 0);
      check_eq("rst_irq", int'(bus.irq_o), 0);
      rstn = 1'b1;

      // 07:30:00 alarm against a 12 h AM clock, exact match on all fields
      set_time(6'd59, 6'd29, 6'd7, 2'b01);
      program_alarm(6'd0, 6'd30, 5'd7, 5'd1, 1'b1, 4'b0000);
      bus.alarm_en_i = 1'b1;
      step();
      check_eq("t1_pre_irq", int'(bus.irq_o), 0);
      check_eq("t1_pre_ring", int'(bus.ring_o), 0);
      set_time(6'd0, 6'd30, 6'd7, 2'b01);
      step();
      check_eq("t1_ring_on", int'(bus.ring_o), 1);
      check_eq("t1_flag", int'(bus.alarm_flag_o), 1);
      ring_n = 0;
      irq_n  = 0;
      repeat (100) begin
         if (bus.ring_o) ring_n++;
         if (bus.irq_o) irq_n++;
         step();
      end
      check_eq("t1_ring_len", ring_n, 60);
      check_eq("t1_irq_pulses", irq_n, 1);
      check_eq("t1_idle", int'(bus.ring_o), 0);

      // Sticky flag: plain clear, then set-vs-clear collision, then clear again
      bus.flag_clr_i = 1'b1;
      step();
      check_eq("t5_clr", int'(bus.alarm_flag_o), 0);
      bus.flag_clr_i = 1'b0;
      set_time(6'd1, 6'd30, 6'd7, 2'b01);
      step();
      set_time(6'd0, 6'd30, 6'd7, 2'b01);
      bus.flag_clr_i = 1'b1;
      step();
      check_eq("t5_set_wins", int'(bus.alarm_flag_o), 1);
      check_eq("t5_irq", int'(bus.irq_o), 1);
      step();
      check_eq("t5_clr_next", int'(bus.alarm_flag_o), 0);
      bus.flag_clr_i = 1'b0;

      // Hour normalisation at midnight/noon and for PM hours
      program_alarm(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 4'b1000);
      try_time("t2_12am", 6'd12, 2'b01, 1);
      try_time("t2_12pm", 6'd12, 2'b11, 0);
      try_time("t2_24h_00", 6'd0, 2'b00, 1);
      try_time("t2_24h_12", 6'd12, 2'b00, 0);
      program_alarm(6'd0, 6'd0, 5'd19, 5'd0, 1'b0, 4'b1000);
      try_time("t2_7pm", 6'd7, 2'b11, 1);
      try_time("t2_7am", 6'd7, 2'b01, 0);

      // All fields masked: one irq per seconds change, none while stalled
      set_time(6'd9, 6'd0, 6'd0, 2'b00);
      program_alarm(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 4'b1111);
      irq_n = 0;
      for (int k = 0; k < 5; k++) begin
         bus.cur_sec_i = 6'(10 + k);
         step();
         if (bus.irq_o) irq_n++;
      end
      check_eq("t3_irq_moving", irq_n, 5);
      irq_n = 0;
      repeat (5) begin
         step();
         if (bus.irq_o) irq_n++;
      end
      check_eq("t3_irq_stalled", irq_n, 0);

      // Three full snoozes of 300 ticks, fourth request stops the alarm
      bus.cur_sec_i = 6'd20;
      program_alarm(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 4'b1111);
      bus.cur_sec_i = 6'd21;
      step();
      check_eq("t4_ring", int'(bus.ring_o), 1);
      for (int s = 1; s <= 3; s++) begin
         pulse_snooze();
         snz_n = 0;
         for (int i = 0; i < 400; i++) begin
            if (!bus.snoozing_o) break;
            snz_n++;
            step();
         end
         check_eq($sformatf("t4_snooze%0d_len", s), snz_n, 300);
         check_eq($sformatf("t4_rering%0d", s), int'(bus.ring_o), 1);
      end
      pulse_snooze();
      check_eq("t4_limit_ring", int'(bus.ring_o), 0);
      check_eq("t4_limit_snoozing", int'(bus.snoozing_o), 0);

      // Reset mid-ring, then alarm_wr / alarm_en / stop forcing IDLE
      bus.cur_sec_i = 6'd22;
      step();
      check_eq("t6_ring", int'(bus.ring_o), 1);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      check_eq("t6_rst_ring", int'(bus.ring_o), 0);
      check_eq("t6_rst_flag", int'(bus.alarm_flag_o), 0);
      bus.cur_sec_i = 6'd23;
      step();
      check_eq("t6_rst_mask_irq", int'(bus.irq_o), 1);
      pulse_snooze();
      check_eq("t6_snoozing", int'(bus.snoozing_o), 1);
      program_alarm(6'd0, 6'd0, 5'd0, 5'd0, 1'b0, 4'b1111);
      check_eq("t6_wr_snoozing", int'(bus.snoozing_o), 0);
      check_eq("t6_wr_ring", int'(bus.ring_o), 0);
      bus.cur_sec_i = 6'd24;
      step();
      pulse_snooze();
      check_eq("t6_snoozing2", int'(bus.snoozing_o), 1);
      bus.alarm_en_i = 1'b0;
      step();
      check_eq("t6_en_snoozing", int'(bus.snoozing_o), 0);
      bus.cur_sec_i = 6'd25;
      step();
      check_eq("t6_en_irq", int'(bus.irq_o), 0);
      bus.alarm_en_i = 1'b1;
      bus.cur_sec_i = 6'd26;
      step();
      check_eq("t6_ring2", int'(bus.ring_o), 1);
      bus.stop_i = 1'b1;
      step();
      bus.stop_i = 1'b0;
      check_eq("t6_stop_ring", int'(bus.ring_o), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
